wbm_rr_arbiter: RTL
===================

Name: wbm_rr_arbiter

Overview:
- Shares one Wishbone classic slave-side port between NUM_MASTERS bus masters: monitor CPU, host interface and sequencer, for example.
- Round-robin arbitration, one outstanding transaction at a time.
- Built-in per-transaction watchdog: if the slave never acks, the arbiter returns an error-ack so the granted master cannot hang the bus.
- Sits upstream of the slave address decoder; keeps a saturating count of timeout events for monitoring.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..4).
- TIMEOUT, 20'd1023, cycles in ACTIVE without s_ack before an error-ack is forced (minimum 1).
- ERR_DATA, 16'hDEAD, read data returned to the master on timeout.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_cyc  in  NUM_MASTERS  per-master cycle request; bit i belongs to master i.
- m_stb  in  NUM_MASTERS  per-master strobe.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_adr  in  16*NUM_MASTERS  packed addresses; master i uses [16i+15:16i].
- m_dat_i  in  16*NUM_MASTERS  packed write data.
- m_dat_o  out  16  read data, shared by all masters; valid only with that master's m_ack.
- m_ack  out  NUM_MASTERS  one-hot single-cycle ack to the granted master.
- m_err  out  NUM_MASTERS  one-hot; pulses with m_ack when the transaction timed out.
- s_cyc  out  1  slave-side cycle.
- s_stb  out  1  slave-side strobe.
- s_we  out  1  slave-side write enable.
- s_adr  out  16  slave-side address.
- s_dat_o  out  16  slave-side write data.
- s_dat_i  in  16  slave read data.
- s_ack  in  1  slave acknowledge.
- grant  out  NUM_MASTERS  one-hot current owner; zero when idle.
- timeout_cnt  out  16  saturating count of timeout events.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0; state IDLE; timeout counter 0; timeout_cnt 0.
  - last_grant = NUM_MASTERS-1, so master 0 has top priority on the first arbitration.
- A master is requesting when m_cyc[i] & m_stb[i].
- IDLE:
  - If any master is requesting, pick the first requester searching from index (last_grant+1) mod NUM_MASTERS upward with wrap.
  - Register grant, last_grant, and the winner's we/adr/dat into the s_* outputs.
  - Assert s_cyc and s_stb; go to ACTIVE on the next edge. Latency from request to s_stb is one cycle.
  - No request: remain in IDLE.
- ACTIVE:
  - s_* outputs held stable; the watchdog counter increments each cycle, starting at 0.
  - s_ack sampled high:
    - Latch s_dat_i into m_dat_o.
    - Next cycle: m_ack[g]=1 pulse, s_cyc/s_stb drop.
    - Go to DONE.
  - Counter reaches TIMEOUT-1 with s_ack low:
    - m_dat_o=ERR_DATA.
    - Next cycle: m_ack[g]=1 and m_err[g]=1, s_cyc/s_stb drop.
    - timeout_cnt+1, saturating at 16'hFFFF.
    - Go to DONE.
  - s_ack and timeout in the same cycle: the ack wins, no error, timeout_cnt unchanged.
  - Granted master drops m_cyc (abort):
    - Go to IDLE; s_cyc/s_stb drop next cycle.
    - No m_ack; grant cleared; last_grant still advances.
- DONE:
  - One cycle; m_ack/m_err high this cycle only; grant still valid.
  - Next state is IDLE with grant=0 and counter cleared.
  - The master deasserts stb after the ack. A fresh request is arbitrated in IDLE, giving one bubble cycle minimum between transactions.
- Fairness: a continuously requesting master cannot win twice in a row while another master is requesting.
- m_dat_o holds its last value outside acks.
- Non-granted masters see m_ack=m_err=0.

Test Plan:
- Reset release, master1 only, read adr 16'h0040, slave acks 3 cycles after s_stb with 16'h1234 -> grant=3'b010; s_adr=0040; m_ack[1] pulses 1 cycle with m_dat_o=1234; m_err=0.
- All 3 masters requesting continuously, slave acks immediately -> grant order 0,1,2,0,1,2; each grant separated by DONE plus an IDLE bubble.
- Master0 write to 16'h0100, slave never acks, TIMEOUT=1023 -> s_stb high exactly 1023 cycles; then m_ack[0]=m_err[0]=1, m_dat_o=DEAD; timeout_cnt=1; master2 granted next if requesting.
- s_ack asserted on the exact timeout cycle -> normal ack with slave data, m_err=0, timeout_cnt unchanged.
- Master2 drops m_cyc 5 cycles into ACTIVE -> no ack to master2; s_cyc low next cycle; next arbitration starts from master0.
- reset pulled low mid-ACTIVE -> s_cyc/s_stb/grant/m_ack go 0 immediately (asynchronously); after release master0 has priority; timeout_cnt=0.

Source files
------------

// File: rtl/wbm_rr_arbiter.sv
// rtl/wbm_rr_arbiter.sv - round-robin Wishbone classic arbiter with per-transaction watchdog
module wbm_rr_arbiter #(
    parameter int          NUM_MASTERS = 3,
    parameter logic [19:0] TIMEOUT     = 20'd1023,
    parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MASTERS-1:0]     m_cyc,
    input  logic [NUM_MASTERS-1:0]     m_stb,
    input  logic [NUM_MASTERS-1:0]     m_we,
    input  logic [16*NUM_MASTERS-1:0]  m_adr,
    input  logic [16*NUM_MASTERS-1:0]  m_dat_i,
    output logic [15:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]     m_ack,
    output logic [NUM_MASTERS-1:0]     m_err,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [15:0]                s_adr,
    output logic [15:0]                s_dat_o,
    input  logic [15:0]                s_dat_i,
    input  logic                       s_ack,
    output logic [NUM_MASTERS-1:0]     grant,
    output logic [15:0]                timeout_cnt
);

    localparam int IDX_W = (NUM_MASTERS > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        win_idx;
    logic                    any_req;
    logic                    win_we;
    logic [15:0]             win_adr;
    logic [15:0]             win_dat;
    logic [NUM_MASTERS-1:0]  req;
    logic [NUM_MASTERS-1:0]  win_onehot;
    logic [NUM_MASTERS-1:0]  own_onehot;
    logic [19:0]             wdog;
    logic                    own_cyc;
    logic                    ack_evt;
    logic                    to_evt;
    logic                    abort_evt;

    assign req        = m_cyc & m_stb;
    assign win_onehot = NUM_MASTERS'(1) << win_idx;
    // last_grant doubles as the index of the current owner while ACTIVE/DONE
    assign own_onehot = NUM_MASTERS'(1) << last_grant;
    assign own_cyc    = |(m_cyc & own_onehot);
    // Slave ack beats the watchdog; abort only counts when neither fired
    assign ack_evt    = s_ack;
    assign to_evt     = !s_ack && (wdog == TIMEOUT - 20'd1);
    assign abort_evt  = !s_ack && !to_evt && !own_cyc;

    // Round-robin pick: first requester above last_grant, else wrap to the lowest one
    always_comb begin
        win_idx = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!any_req && req[i] && (IDX_W'(i) > last_grant)) begin
                any_req = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!any_req && req[i]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    // Select the winning master's command fields
    always_comb begin
        win_we  = 1'b0;
        win_adr = '0;
        win_dat = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_we  = m_we[i];
                win_adr = m_adr[16*i +: 16];
                win_dat = m_dat_i[16*i +: 16];
            end
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACTIVE;
            ACTIVE: begin
                if (ack_evt || to_evt) state_next = DONE;
                else if (abort_evt)    state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Grant, slave-side command, watchdog and master response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= IDX_W'(NUM_MASTERS - 1);
            grant       <= '0;
            s_cyc       <= 1'b0;
            s_stb       <= 1'b0;
            s_we        <= 1'b0;
            s_adr       <= '0;
            s_dat_o     <= '0;
            m_dat_o     <= '0;
            m_ack       <= '0;
            m_err       <= '0;
            wdog        <= '0;
            timeout_cnt <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (any_req) begin
                        grant      <= win_onehot;
                        last_grant <= win_idx;
                        s_cyc      <= 1'b1;
                        s_stb      <= 1'b1;
                        s_we       <= win_we;
                        s_adr      <= win_adr;
                        s_dat_o    <= win_dat;
                    end
                end
                ACTIVE: begin
                    wdog <= wdog + 20'd1;
                    if (ack_evt) begin
                        m_dat_o <= s_dat_i;
                        m_ack   <= own_onehot;
                        s_cyc   <= 1'b0;
                        s_stb   <= 1'b0;
                    end else if (to_evt) begin
                        m_dat_o <= ERR_DATA;
                        m_ack   <= own_onehot;
                        m_err   <= own_onehot;
                        s_cyc   <= 1'b0;
                        s_stb   <= 1'b0;
                        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                    end else if (abort_evt) begin
                        s_cyc <= 1'b0;
                        s_stb <= 1'b0;
                        grant <= '0;
                    end
                end
                DONE: begin
                    grant <= '0;
                    wdog  <= '0;
                end
                default: begin
                    grant <= '0;
                    s_cyc <= 1'b0;
                    s_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule
